// File: rtl/gs_unit.sv
// Pipelined inverse-NTT Gentleman-Sande butterfly for ML-DSA coefficients.
// A_out = (A+B) mod Q, B_out = ((A-B) mod Q)*zeta mod Q, optionally halved.
module gs_unit #(
   parameter int unsigned Q       = 8380417,
   parameter int unsigned WIDTH   = 23,
   parameter int unsigned LATENCY = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   input  logic [WIDTH-1:0] zeta,
   input  logic             half,
   output logic [WIDTH-1:0] A_out,
   output logic [WIDTH-1:0] B_out,
   output logic             valid
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned MW = WIDTH + 2;
   localparam logic [WIDTH-1:0] QV  = WIDTH'(Q);
   localparam logic [PW-1:0]    QP  = PW'(Q);
   localparam logic [PW-1:0]    Q2P = PW'(2 * Q);
   // Barrett constant floor(2^PW / Q); the product is always below 2^PW
   localparam logic [MW-1:0]    MU  = MW'((64'd1 << PW) / 64'(Q));

   logic [LATENCY-1:0] vpipe;

   logic [WIDTH-1:0] s1_a, s1_b, s1_z;
   logic             s1_h;
   logic [WIDTH-1:0] s2_sum, s2_diff, s2_z;
   logic             s2_h;
   logic [WIDTH-1:0] s3_sum;
   logic [PW-1:0]    s3_prod;
   logic             s3_h;
   logic [WIDTH-1:0] s4_sum;
   logic [PW-1:0]    s4_prod;
   logic [MW-1:0]    s4_q;
   logic             s4_h;

   logic [WIDTH:0]      sum_c;
   logic [WIDTH-1:0]    sum_red_c;
   logic [WIDTH-1:0]    diff_c;
   logic [PW+MW-1:0]    qmul_c;
   logic [MW-1:0]       q_c;
   logic [PW-1:0]       r_c;
   logic [WIDTH-1:0]    prod_red_c;

   // Multiply by 2^-1 mod Q: odd values borrow one Q before the shift
   function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] x, input logic h);
      logic [WIDTH:0] t;
      t = x[0] ? ({1'b0, x} + {1'b0, QV}) : {1'b0, x};
      return h ? WIDTH'(t >> 1) : x;
   endfunction

   always_comb begin
      sum_c     = {1'b0, s1_a} + {1'b0, s1_b};
      sum_red_c = (sum_c >= {1'b0, QV}) ? WIDTH'(sum_c - {1'b0, QV}) : WIDTH'(sum_c);
      diff_c    = (s1_a >= s1_b) ? (s1_a - s1_b) : (s1_a - s1_b + QV);
   end

   always_comb begin
      qmul_c = {{MW{1'b0}}, s3_prod} * {{PW{1'b0}}, MU};
      q_c    = MW'(qmul_c >> PW);
   end

   // Barrett remainder lands below 2Q; the 2Q arm is a cheap safety margin
   always_comb begin
      r_c = s4_prod - ({{(PW-MW){1'b0}}, s4_q} * {{WIDTH{1'b0}}, QV});
      if (r_c >= Q2P) begin
         prod_red_c = WIDTH'(r_c - Q2P);
      end else if (r_c >= QP) begin
         prod_red_c = WIDTH'(r_c - QP);
      end else begin
         prod_red_c = WIDTH'(r_c);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vpipe <= '0;
      end else begin
         vpipe <= {vpipe[LATENCY-2:0], en};
      end
   end

   // Datapath stages carry no reset; vpipe alone qualifies them
   always_ff @(posedge clk) begin
      if (en) begin
         s1_a <= A_in;
         s1_b <= B_in;
         s1_z <= zeta;
         s1_h <= half;
      end
      s2_sum  <= sum_red_c;
      s2_diff <= diff_c;
      s2_z    <= s1_z;
      s2_h    <= s1_h;
      s3_sum  <= s2_sum;
      s3_prod <= {{WIDTH{1'b0}}, s2_diff} * {{WIDTH{1'b0}}, s2_z};
      s3_h    <= s2_h;
      s4_sum  <= s3_sum;
      s4_prod <= s3_prod;
      s4_q    <= q_c;
      s4_h    <= s3_h;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         A_out <= '0;
         B_out <= '0;
      end else begin
         valid <= vpipe[LATENCY-1];
         if (vpipe[LATENCY-1]) begin
            A_out <= halve(s4_sum, s4_h);
            B_out <= halve(prod_red_c, s4_h);
         end
      end
   end

endmodule

// File: doc/gs_unit.md
GS_UNIT -- requirements
Module: gs_unit

Interface
REQ-001 The module SHALL have parameter Q, default 8380417, meaning the ML-DSA prime modulus.
REQ-002 The module SHALL have parameter WIDTH, default 23, meaning the coefficient width in bits.
REQ-003 The module SHALL have parameter LATENCY, default 4, meaning the cycles from en sample to valid; it is fixed and not tunable by users.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: the reset, synchronous and active-high.
REQ-006 The module SHALL have port en, input, 1 bit: launches one butterfly operation when sampled high.
REQ-007 The module SHALL have port A_in, input, WIDTH bits: first coefficient, range [0, Q-1].
REQ-008 The module SHALL have port B_in, input, WIDTH bits: second coefficient, range [0, Q-1].
REQ-009 The module SHALL have port zeta, input, WIDTH bits: twiddle factor (inverse root power), range [0, Q-1].
REQ-010 The module SHALL have port half, input, 1 bit: when 1, both results are additionally multiplied by 2^-1 mod Q (4190209).
REQ-011 The module SHALL have port A_out, output, WIDTH bits: sum result.
REQ-012 The module SHALL have port B_out, output, WIDTH bits: twiddled difference result.
REQ-013 The module SHALL have port valid, output, 1 bit: A_out/B_out hold a new result this cycle.

Function
REQ-014 The module SHALL implement the inverse-NTT Gentleman-Sande butterfly, the counterpart of the forward Cooley-Tukey BT_unit.
REQ-015 The module SHALL compute A_out = (A_in + B_in) mod Q; conditional subtract of Q when the sum is >= Q.
REQ-016 The module SHALL compute B_out = ((A_in - B_in) mod Q) * zeta mod Q; the difference adds Q when A_in < B_in; the full 46-bit product is reduced to [0, Q-1].
REQ-017 When half=1, each result x SHALL be replaced by x/2 for even x, (x+Q)/2 for odd x; half SHALL be applied after the REQ-015/016 values.
REQ-018 A_in, B_in, zeta and half SHALL be captured on the same edge that samples en=1; inputs are ignored when en=0.
REQ-019 Results of an op sampled at edge k SHALL appear on A_out/B_out with valid=1 after edge k+LATENCY, for exactly one cycle.
REQ-020 The pipeline SHALL accept en=1 on every cycle (throughput 1 op/cycle), with no stall and no backpressure.
REQ-021 Ops SHALL emerge in issue order; en=0 bubbles SHALL propagate as valid=0 cycles at the same positions.
REQ-022 A_out/B_out SHALL hold their last value while valid=0.
REQ-023 All outputs SHALL be in [0, Q-1] for in-range inputs; for inputs >= Q, outputs are unspecified, and the bench SHALL NOT drive such inputs.

Reset
REQ-024 reset=1 at an edge SHALL clear valid, A_out, B_out and every pipeline valid bit to 0.
REQ-025 reset SHALL take precedence over en in the same cycle; that op is discarded.
REQ-026 Ops in flight when reset asserts SHALL be discarded; valid SHALL never rise for them.
REQ-027 The first en=1 sampled after reset deasserts SHALL produce valid LATENCY cycles later, with no extra warm-up.

Verification
REQ-028 The bench SHALL cover: A=1, B=3, zeta=3383, half=0 -> valid after 4 edges, A_out=4, B_out=8373651; same with half=1 -> A_out=2, B_out=8377034.
REQ-029 The bench SHALL cover wrap: A=8380416, B=1, zeta=1 -> A_out=0, B_out=8380415; and A=B=8380416, zeta=2 -> A_out=8380415, B_out=0.
REQ-030 The bench SHALL cover negative twiddle: A=0, B=1, zeta=8380416 -> A_out=1, B_out=1.
REQ-031 The bench SHALL cover back-to-back issue: en high 3 cycles, then low 1, then high 1 -> valid pattern 1,1,1,0,1 starting 4 cycles after the first, results in order.
REQ-032 The bench SHALL cover reset mid-flight: issue an op, assert reset 2 cycles later for 1 cycle -> valid stays 0, A_out=B_out=0; the next op after reset completes in 4 cycles.
REQ-033 The bench SHALL run a random regression of at least 10000 in-range ops with random en, compared against a golden model using REQ-015 to REQ-017.
